argon_regfile_sequencer: RTL
============================

Name: argon_regfile_sequencer

Overview:
- Bus initiator that drives the register file's bus and control strobes (select-latch, output-A, output-B, latch-C) from a single register-operation request.
- Sequences one request as: index select, optional read of rA, optional read of rB, optional write of rC. Returns the read values on a valid/ready response channel.
- Sits between the decode/execute control logic and the register-file responder on the shared bus.

Parameters:
- DATA_W, 16, bus and register word width
- IDX_W, 4, register index width (16 registers; index 0 reads as zero)

Ports:
- i_Clk  in  1  clock
- i_Reset  in  1  synchronous, active-high reset
- i_req_valid  in  1  request valid
- o_req_ready  out  1  high only in IDLE
- i_req_rA / i_req_rB / i_req_rC  in  IDX_W each  register indices
- i_req_read_a / i_req_read_b / i_req_write_c  in  1 each  operation flags
- i_req_wdata  in  DATA_W  data to write to rC
- o_bus_data  out  DATA_W  word driven to responder
- o_bus_valid  out  1  bus word valid (responder's input-valid)
- i_bus_data  in  DATA_W  responder's registered output data
- i_bus_valid  in  1  responder's output-valid
- o_selectLatch / o_outputA / o_outputB / o_latchC  out  1 each  control strobes
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response accepted
- o_rsp_a / o_rsp_b  out  DATA_W  read results
- o_err  out  1  sticky protocol error

Behaviour:
- Reset (synchronous, i_Reset high at a rising i_Clk edge):
  - state goes to IDLE.
  - All outputs are 0 except o_req_ready=1.
  - Request latches are cleared.
  - Reset mid-operation aborts without issuing further strobes.
- Request handshake: accepted when i_req_valid && o_req_ready. All request fields are latched at that edge.
- States: IDLE, SELECT, RD_A, RD_B, CAP, WR_C, RSP.
- Per-state outputs:
  - SELECT: o_bus_valid=1, o_selectLatch=1, o_bus_data = {4'b0, rC, rB, rA}.
  - RD_A: o_outputA=1, o_bus_valid=0.
  - RD_B: o_outputB=1, o_bus_valid=0.
  - CAP: no strobes.
  - WR_C: o_bus_valid=1, o_latchC=1, o_bus_data = wdata.
  - RSP: o_rsp_valid=1; hold until i_rsp_ready, then go to IDLE.
- Transitions:
  - IDLE → SELECT on accept.
  - SELECT → RD_A if read_a, else RD_B if read_b, else WR_C if write_c, else RSP.
  - RD_A → RD_B if read_b, else CAP.
  - RD_B → CAP.
  - CAP → WR_C if write_c, else RSP.
  - WR_C → RSP.
- Capture rule: the responder's data is registered, so data strobed in cycle N is sampled from i_bus_data in cycle N+1.
  - The cycle after RD_A loads o_rsp_a.
  - The cycle after RD_B loads o_rsp_b.
  - Implement with pending-capture flags.
- Unread result fields are cleared to 0 at accept.
- At most one control strobe per cycle. o_bus_valid is never high in RD_A/RD_B.
- Ordering: reads precede the write, so rC==rA returns the pre-write value.
- Latency from accept edge to o_rsp_valid:
  - read A + read B + write C: 6 cycles.
  - read A + read B: 5 cycles.
  - write only: 3 cycles.
  - no flags: 2 cycles.
- o_err is set (sticky until reset):
  - if i_bus_valid==0 in RD_A or RD_B, or
  - if i_bus_valid==1 in any cycle with neither o_outputA nor o_outputB asserted.
- o_rsp_a, o_rsp_b and o_rsp_valid are stable while o_rsp_valid && !i_rsp_ready.

Optional Feature:
- Macro: ARGON_SEQ_R0_SKIP_EN.
- Defined:
  - a read of index 0 skips its RD state and returns 0 without a bus cycle.
  - if both skipped reads leave no capture pending, CAP is skipped as well.
  - read_a with rA=0 plus read_b with rB=5: 4-cycle latency.
- Undefined: index-0 reads are issued normally; the responder returns 0.

Decomposition:
- argon_pkg gains:
  - word_t (existing), reg_idx_t.
  - seq_state_t enum.
  - select-word field offsets: SEL_A_LSB=0, SEL_B_LSB=4, SEL_C_LSB=8.
- No sub-module; a single FSM with datapath registers.

Test Plan:
- Reset, then preload via write_c: rC=3, wdata=16'hBEEF → WR_C strobe with data BEEF at cycle 2; o_rsp_valid at cycle 3.
- Read-only, paired with the register-file model holding r3=BEEF, r5=1234: read_a rA=3, read_b rB=5 → o_rsp_a=BEEF, o_rsp_b=1234, o_rsp_valid at cycle 5, one strobe per cycle.
- rA=rC=3, read_a + write_c with wdata=0x0042 → o_rsp_a=BEEF (old value); a following read of r3 returns 0042.
- Response backpressure: i_rsp_ready low for 4 cycles → rsp outputs held stable, o_req_ready=0; release → IDLE next cycle.
- Fault injection: force i_bus_valid=0 during RD_A → o_err=1, persisting until i_Reset.
- Reset asserted during RD_B → next cycle all strobes 0, o_req_ready=1, o_rsp_valid=0; with ARGON_SEQ_R0_SKIP_EN, rA=0 read completes without asserting o_outputA.

Source files
------------

// File: rtl/argon_pkg.sv
// Shared types and constants for the argon register-file sequencer.
// The optional index-0 read skip is enabled with the ARGON_SEQ_R0_SKIP_EN macro.
package argon_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned IDX_W_DEF  = 4;

  typedef logic [DATA_W_DEF-1:0] word_t;
  typedef logic [IDX_W_DEF-1:0]  reg_idx_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_RD_A,
    S_RD_B,
    S_CAP,
    S_WR_C,
    S_RSP
  } seq_state_t;

  // Bit offsets of the three register indices inside the select word
  localparam int unsigned SEL_A_LSB = 0;
  localparam int unsigned SEL_B_LSB = 4;
  localparam int unsigned SEL_C_LSB = 8;

endpackage

// File: rtl/argon_regfile_sequencer.sv
// Bus initiator that sequences select / read A / read B / write C strobes to the register file.
// Defining ARGON_SEQ_R0_SKIP_EN skips the bus cycle for reads of index 0.
module argon_regfile_sequencer
  import argon_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IDX_W  = IDX_W_DEF
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [IDX_W-1:0]  i_req_rA,
  input  logic [IDX_W-1:0]  i_req_rB,
  input  logic [IDX_W-1:0]  i_req_rC,
  input  logic              i_req_read_a,
  input  logic              i_req_read_b,
  input  logic              i_req_write_c,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic [DATA_W-1:0] o_bus_data,
  output logic              o_bus_valid,
  input  logic [DATA_W-1:0] i_bus_data,
  input  logic              i_bus_valid,
  output logic              o_selectLatch,
  output logic              o_outputA,
  output logic              o_outputB,
  output logic              o_latchC,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_a,
  output logic [DATA_W-1:0] o_rsp_b,
  output logic              o_err
);

  seq_state_t        state_q, state_d;
  logic [IDX_W-1:0]  ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_a_q, rd_a_d, rd_b_q, rd_b_d, wr_c_q, wr_c_d;
  logic              cap_a_q, cap_a_d, cap_b_q, cap_b_d;
  logic [DATA_W-1:0] rsp_a_q, rsp_a_d, rsp_b_q, rsp_b_d;
  logic              req_ready_q, req_ready_d;
  logic              bus_valid_q, bus_valid_d;
  logic [DATA_W-1:0] bus_data_q, bus_data_d;
  logic              sel_q, sel_d, outa_q, outa_d, outb_q, outb_d, latc_q, latc_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              err_q, err_d;
  logic              acc_rd_a, acc_rd_b;
  logic [DATA_W-1:0] sel_word;

  // Reads that actually need a bus cycle
`ifdef ARGON_SEQ_R0_SKIP_EN
  assign acc_rd_a = i_req_read_a && (i_req_rA != '0);
  assign acc_rd_b = i_req_read_b && (i_req_rB != '0);
`else
  assign acc_rd_a = i_req_read_a;
  assign acc_rd_b = i_req_read_b;
`endif

  always_comb begin
    state_d  = state_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rc_d     = rc_q;
    wdata_d  = wdata_q;
    rd_a_d   = rd_a_q;
    rd_b_d   = rd_b_q;
    wr_c_d   = wr_c_q;
    rsp_a_d  = rsp_a_q;
    rsp_b_d  = rsp_b_q;
    sel_word = '0;

    // Responder data is registered: capture one cycle after the read strobe
    cap_a_d = (state_q == S_RD_A);
    cap_b_d = (state_q == S_RD_B);
    if (cap_a_q) rsp_a_d = i_bus_data;
    if (cap_b_q) rsp_b_d = i_bus_data;

    err_d = err_q
          | ((outa_q | outb_q) & ~i_bus_valid)
          | (i_bus_valid & ~outa_q & ~outb_q);

    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          state_d = S_SELECT;
          ra_d    = i_req_rA;
          rb_d    = i_req_rB;
          rc_d    = i_req_rC;
          wdata_d = i_req_wdata;
          rd_a_d  = acc_rd_a;
          rd_b_d  = acc_rd_b;
          wr_c_d  = i_req_write_c;
          rsp_a_d = '0;
          rsp_b_d = '0;
        end
      end
      S_SELECT: begin
        if (rd_a_q)      state_d = S_RD_A;
        else if (rd_b_q) state_d = S_RD_B;
        else if (wr_c_q) state_d = S_WR_C;
        else             state_d = S_RSP;
      end
      S_RD_A:  state_d = rd_b_q ? S_RD_B : S_CAP;
      S_RD_B:  state_d = S_CAP;
      S_CAP:   state_d = wr_c_q ? S_WR_C : S_RSP;
      S_WR_C:  state_d = S_RSP;
      S_RSP:   if (i_rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    sel_word[SEL_A_LSB +: IDX_W] = ra_d;
    sel_word[SEL_B_LSB +: IDX_W] = rb_d;
    sel_word[SEL_C_LSB +: IDX_W] = rc_d;

    // Outputs are registered and track the state being entered
    req_ready_d = (state_d == S_IDLE);
    sel_d       = (state_d == S_SELECT);
    outa_d      = (state_d == S_RD_A);
    outb_d      = (state_d == S_RD_B);
    latc_d      = (state_d == S_WR_C);
    rsp_valid_d = (state_d == S_RSP);
    bus_valid_d = sel_d | latc_d;
    bus_data_d  = '0;
    if (sel_d)  bus_data_d = sel_word;
    if (latc_d) bus_data_d = wdata_d;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q     <= S_IDLE;
      ra_q        <= '0;
      rb_q        <= '0;
      rc_q        <= '0;
      wdata_q     <= '0;
      rd_a_q      <= 1'b0;
      rd_b_q      <= 1'b0;
      wr_c_q      <= 1'b0;
      cap_a_q     <= 1'b0;
      cap_b_q     <= 1'b0;
      rsp_a_q     <= '0;
      rsp_b_q     <= '0;
      req_ready_q <= 1'b1;
      bus_valid_q <= 1'b0;
      bus_data_q  <= '0;
      sel_q       <= 1'b0;
      outa_q      <= 1'b0;
      outb_q      <= 1'b0;
      latc_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      rc_q        <= rc_d;
      wdata_q     <= wdata_d;
      rd_a_q      <= rd_a_d;
      rd_b_q      <= rd_b_d;
      wr_c_q      <= wr_c_d;
      cap_a_q     <= cap_a_d;
      cap_b_q     <= cap_b_d;
      rsp_a_q     <= rsp_a_d;
      rsp_b_q     <= rsp_b_d;
      req_ready_q <= req_ready_d;
      bus_valid_q <= bus_valid_d;
      bus_data_q  <= bus_data_d;
      sel_q       <= sel_d;
      outa_q      <= outa_d;
      outb_q      <= outb_d;
      latc_q      <= latc_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
    end
  end

  assign o_req_ready   = req_ready_q;
  assign o_bus_data    = bus_data_q;
  assign o_bus_valid   = bus_valid_q;
  assign o_selectLatch = sel_q;
  assign o_outputA     = outa_q;
  assign o_outputB     = outb_q;
  assign o_latchC      = latc_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_a       = rsp_a_q;
  assign o_rsp_b       = rsp_b_q;
  assign o_err         = err_q;

endmodule
